// File: rtl/mcp_main_control.sv
// Multicycle MIPS main controller: Moore FSM plus ALU decoder. Outputs are combinational from state, and the FETCH strobes are gated by MEM_READY.
// Latency is 3-5 cycles per instruction; MEM_READY=0 holds FETCH, MEMRD and MEMWR, and each held cycle adds one cycle.
module mcp_main_control #(
    parameter int OPW = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] OP,
    input  logic [OPW-1:0] FUNCT,
    input  logic           ZERO,
    input  logic           MEM_READY,
    output logic           IorD,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUControl,
    output logic           IRWrite,
    output logic           MemWrite,
    output logic           RegWrite,
    output logic           PCEn,
    output logic           ILLEGAL_OP,
    output logic [3:0]     STATE
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t     state_q, state_d, cur;
    logic       illegal_q, illegal_d;
    logic       ir_write, mem_write, reg_write, pc_write, branch;
    logic [1:0] alu_op;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset presents FETCH decode immediately so no mux select glitches mid-instruction.
    assign cur = RST ? FETCH : state_q;

    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        IorD      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        PCSrc     = 2'b00;
        alu_op    = 2'b00;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        case (cur)
            FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = MEM_READY;
                pc_write = MEM_READY;
                state_d  = MEM_READY ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (OP)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (OP == OP_LW)      state_d = MEMRD;
                else if (OP == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MEM_READY ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                state_d   = MEM_READY ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b010;
        case (alu_op)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (FUNCT)
                    OPW'(6'b100010): ALUControl = 3'b110;
                    OPW'(6'b100100): ALUControl = 3'b000;
                    OPW'(6'b100101): ALUControl = 3'b001;
                    OPW'(6'b101010): ALUControl = 3'b111;
                    default:         ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign IRWrite    = ir_write  & ~RST;
    assign MemWrite   = mem_write & ~RST;
    assign RegWrite   = reg_write & ~RST;
    assign PCEn       = ~RST & (pc_write | (branch & ZERO));
    assign ILLEGAL_OP = illegal_q;
    assign STATE      = cur;
endmodule

// File: tb/tb_mcp_main_control.sv
// Bench for mcp_main_control: per-opcode state paths and a per-state control table form the reference,
// driven with directed cases followed by randomized instructions, memory stalls and ZERO values.
module tb_mcp_main_control;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] OP = 6'd0;
    logic [5:0] FUNCT = 6'd0;
    logic       ZERO = 1'b0;
    logic       MEM_READY = 1'b1;
    logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, PCEn, ILLEGAL_OP;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] STATE;

    mcp_main_control dut (
        .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_READY(MEM_READY),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .PCEn(PCEn), .ILLEGAL_OP(ILLEGAL_OP), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       iord, srca;
        logic [1:0] srcb;
        logic       regdst, memtoreg;
        logic [1:0] pcsrc, aluop;
        logic       irw, memw, regw, pcw, branch;
    } ctl_t;

    ctl_t tbl [0:11];
    int   errors = 0;
    int   checks = 0;
    bit   exp_ill = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [5:0] f);
        if (aluop == 2'b01) return 3'b110;
        if (aluop == 2'b10) begin
            case (f)
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b010;
            endcase
        end
        return 3'b010;
    endfunction

    task automatic check(input int s, input bit rst);
        ctl_t c;
        logic gate, e_irw, e_pcw, e_pcen;
        c      = tbl[s];
        gate   = (s != 0) || MEM_READY;
        e_irw  = c.irw & gate & !rst;
        e_pcw  = c.pcw & gate;
        e_pcen = !rst & (e_pcw | (c.branch & ZERO));
        chk($sformatf("STATE s%0d rst%0d", s, rst), 8'(STATE), 8'(s));
        chk($sformatf("IorD s%0d", s), 8'(IorD), 8'(c.iord));
        chk($sformatf("ALUSrcA s%0d", s), 8'(ALUSrcA), 8'(c.srca));
        chk($sformatf("ALUSrcB s%0d", s), 8'(ALUSrcB), 8'(c.srcb));
        chk($sformatf("RegDst s%0d", s), 8'(RegDst), 8'(c.regdst));
        chk($sformatf("MemtoReg s%0d", s), 8'(MemtoReg), 8'(c.memtoreg));
        chk($sformatf("PCSrc s%0d", s), 8'(PCSrc), 8'(c.pcsrc));
        chk($sformatf("ALUControl s%0d funct%0h", s, FUNCT), 8'(ALUControl), 8'(alu_ref(c.aluop, FUNCT)));
        chk($sformatf("IRWrite s%0d rst%0d", s, rst), 8'(IRWrite), 8'(e_irw));
        chk($sformatf("MemWrite s%0d rst%0d", s, rst), 8'(MemWrite), 8'(c.memw & !rst));
        chk($sformatf("RegWrite s%0d rst%0d", s, rst), 8'(RegWrite), 8'(c.regw & !rst));
        chk($sformatf("PCEn s%0d rst%0d zero%0d", s, rst, ZERO), 8'(PCEn), 8'(e_pcen));
        chk($sformatf("ILLEGAL_OP s%0d", s), 8'(ILLEGAL_OP), 8'(exp_ill));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RST = 1'b1;
            MEM_READY = 1'b1;
            ZERO = 1'($urandom_range(0, 1));
            #1 check(0, 1'b1);
            @(posedge CLK);
            exp_ill = 1'b0;
        end
    endtask

    // fw/mw: not-ready cycles in FETCH / memory states (-1 = random); z: ZERO (-1 = random)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int fw, input int mw, input int z, input int abort_at);
        int path[$];
        int idx = 0, stall = 0, cyc = 0, s, lim;
        bit bad = 1'b0, waitable, ready;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            default: begin
                path = '{0, 1};
                bad  = 1'b1;
            end
        endcase
        while (idx < path.size()) begin
            @(negedge CLK);
            RST   = 1'b0;
            OP    = op;
            FUNCT = funct;
            ZERO  = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
            s        = path[idx];
            lim      = (s == 0) ? fw : mw;
            waitable = (s == 0) || (s == 3) || (s == 5);
            if (!waitable)    ready = 1'($urandom_range(0, 1));
            else if (lim < 0) ready = ($urandom_range(0, 3) != 0);
            else              ready = (stall >= lim);
            MEM_READY = ready;
            #1 check(s, 1'b0);
            if (waitable && !ready) begin
                stall++;
            end else begin
                stall = 0;
                idx++;
                if (bad && s == 1) exp_ill = 1'b1;
            end
            @(posedge CLK);
            cyc++;
            if (abort_at >= 0 && cyc == abort_at) return;
        end
    endtask

    initial begin
        logic [5:0] ops    [0:5] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] functs [0:4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] rop, rf;
        tbl[0]  = 15'b0_0_01_0_0_00_00_1_0_0_1_0;
        tbl[1]  = 15'b0_0_11_0_0_00_00_0_0_0_0_0;
        tbl[2]  = 15'b0_1_10_0_0_00_00_0_0_0_0_0;
        tbl[3]  = 15'b1_0_00_0_0_00_00_0_0_0_0_0;
        tbl[4]  = 15'b0_0_00_0_1_00_00_0_0_1_0_0;
        tbl[5]  = 15'b1_0_00_0_0_00_00_0_1_0_0_0;
        tbl[6]  = 15'b0_1_00_0_0_00_10_0_0_0_0_0;
        tbl[7]  = 15'b0_0_00_1_0_00_00_0_0_1_0_0;
        tbl[8]  = 15'b0_1_00_0_0_01_01_0_0_0_0_1;
        tbl[9]  = 15'b0_1_10_0_0_00_00_0_0_0_0_0;
        tbl[10] = 15'b0_0_00_0_0_00_00_0_0_1_0_0;
        tbl[11] = 15'b0_0_00_0_0_10_00_0_0_0_1_0;

        do_reset(2);
        run_instr(6'b100011, 6'b000000, 0, 0, -1, -1);   // LW
        run_instr(6'b000000, 6'b100010, 0, 0, -1, -1);   // RTYPE sub
        run_instr(6'b000100, 6'b000000, 0, 0, 1, -1);    // BEQ taken
        run_instr(6'b000100, 6'b000000, 0, 0, 0, -1);    // BEQ not taken
        run_instr(6'b101011, 6'b000000, 0, 3, -1, -1);   // SW with 3 MEMWR stalls
        run_instr(6'b001000, 6'b000000, 2, 0, -1, -1);   // ADDI with FETCH stalls
        run_instr(6'b111111, 6'b000000, 0, 0, -1, -1);   // illegal
        run_instr(6'b001000, 6'b000000, 0, 0, -1, -1);   // ADDI after illegal
        run_instr(6'b101011, 6'b000000, 0, 10, -1, 5);   // SW abandoned in MEMWR
        do_reset(1);
        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 6) == 6) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
            rf  = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
            run_instr(rop, rf, -1, -1, -1, -1);
            if (i == 40) do_reset(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mcp_main_control.md
Name: mcp_main_control

Overview:
- Multicycle MIPS main controller: state machine plus ALU decoder.
- Generates every select and enable for the datapath 2:1 muxes (IorD, ALUSrcA, RegDst, MemtoReg), the wider muxes (ALUSrcB, PCSrc), and the register/memory write strobes.
- Sits directly upstream of the mux instances and drives their MUX_SEL inputs.
- Adds a memory-ready wait handshake and a sticky illegal-opcode flag.

Parameters:
- OPW, 6, opcode and funct field width (fixed at 6; parameterised only for readability).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- OP  in  6  instruction opcode, taken from the instruction register.
- FUNCT  in  6  instruction funct field.
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory access completes in the current cycle.
- IorD  out  1  address mux select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = Data register.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUControl  out  3  ALU operation code.
- IRWrite  out  1  instruction register enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- PCEn  out  1  PC enable, equal to PCWrite OR (Branch AND ZERO).
- ILLEGAL_OP  out  1  sticky; set on decode of an unsupported opcode.
- STATE  out  4  current state encoding, for debug and verification.

Behaviour:
- Moore FSM; the state register updates on the rising edge of CLK.
- State encodings (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.
- Reset:
  - RST=1 at an edge sets STATE=FETCH and ILLEGAL_OP=0.
  - While RST=1, IRWrite, MemWrite, RegWrite and PCEn are forced to 0. All other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- Transitions:
  - FETCH to DECODE when MEM_READY=1; otherwise stay in FETCH.
  - DECODE:
    - LW or SW to MEMADR.
    - RTYPE to EXEC.
    - BEQ to BRANCH.
    - ADDI to ADDIEX.
    - J to JUMP.
    - Any other opcode to FETCH, and set ILLEGAL_OP.
  - MEMADR: LW to MEMRD, SW to MEMWR.
  - MEMRD to MEMWB when MEM_READY=1; otherwise hold.
  - MEMWR to FETCH when MEM_READY=1; otherwise hold.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP go to FETCH.
  - EXEC to ALUWB. ADDIEX to ADDIWB.
- Outputs per state. Any output not listed is 0, ALUOp defaults to 00, and PCSrc defaults to 00.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite are asserted only in the cycle where MEM_READY=1 (Mealy-gated).
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1, asserted every cycle spent in the state.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decoder (combinational; ALUOp is internal):
  - ALUOp=00 gives ALUControl=010 (add).
  - ALUOp=01 gives 110 (sub).
  - ALUOp=10 decodes FUNCT:
    - 100000 gives 010 (add).
    - 100010 gives 110 (sub).
    - 100100 gives 000 (and).
    - 100101 gives 001 (or).
    - 101010 gives 111 (slt).
    - Any other FUNCT gives 010 and does not set ILLEGAL_OP.
- PCEn is combinational, equal to PCWrite | (Branch & ZERO).
- Instruction latency with MEM_READY tied to 1, counting FETCH to the return to FETCH:
  - LW: 5 cycles.
  - SW, RTYPE, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each cycle with MEM_READY=0 in FETCH, MEMRD or MEMWR adds 1 cycle.
- ILLEGAL_OP stays set until RST; later instructions execute normally.

Test Plan:
- Reset: RST=1 for 2 cycles with MEM_READY=1 → STATE=0, IRWrite=0, PCEn=0, ILLEGAL_OP=0. After release the first edge gives IRWrite=1, PCEn=1, ALUSrcB=01.
- LW (OP=100011) with MEM_READY=1 → STATE sequence 0,1,2,3,4,0. In state 4, RegWrite=1 and MemtoReg=1. In state 3, IorD=1.
- RTYPE sub (OP=000000, FUNCT=100010) → states 0,1,6,7,0. In EXEC, ALUControl=110. In ALUWB, RegDst=1 and RegWrite=1.
- BEQ: with ZERO=1, BRANCH asserts PCEn=1 and PCSrc=01. Repeat with ZERO=0 → PCEn=0. Both runs return to FETCH after 3 cycles.
- Wait states: SW with MEM_READY=0 for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles, then STATE=0. FETCH with MEM_READY=0 holds IRWrite=0.
- Illegal opcode OP=111111 → DECODE goes to FETCH and ILLEGAL_OP=1, which persists through a following ADDI (states 0,1,9,10,0). RST mid-MEMWR → STATE=0 and MemWrite=0 on the same cycle.
